// File: rtl/shift_stage.sv
// Purpose : one-stage barrel shifter (SLL/SRL/SRA) with a 2-entry in-order result buffer.
// Latency : 1 cycle from input transfer to out_valid when the buffer is empty.
// Backpressure: in_ready drops only when both entries are held; it never looks at out_ready.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   flush               - synchronous discard of every buffered entry
//   in_valid/in_ready   - upstream handshake; in_a operand, in_b amount, in_op op, in_tag tag
//   out_valid/out_ready - downstream handshake; out_o result, out_tag tag, out_err reserved-op flag
module shift_stage #(
    parameter int WIDTH = 32,
    parameter int SHIFT = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [SHIFT-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic [4:0]       in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_o,
    output logic [4:0]       out_tag,
    output logic             out_err
);

    // State encoding equals the number of occupied buffer entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_head;
    logic             r_tail;
    logic [WIDTH-1:0] r_dat [2];
    logic [4:0]       r_tag [2];
    logic             r_err [2];

    logic                    w_in_fire;
    logic                    w_out_fire;
    logic [WIDTH-1:0]        w_res;
    logic                    w_err;
    logic signed [WIDTH-1:0] w_a_s;

    // Handshake flags come from registered state only, so no in_* -> out_* path exists.
    assign in_ready   = (r_state != ST_FULL);
    assign out_valid  = (r_state != ST_EMPTY);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    assign out_o   = r_dat[r_head];
    assign out_tag = r_tag[r_head];
    assign out_err = r_err[r_head];

    assign w_a_s = in_a;

    // Result is computed at acceptance; the reserved op passes the operand through and flags it.
    always_comb begin
        w_res = in_a;
        w_err = 1'b0;
        case (in_op)
            2'b00:   w_res = in_a << in_b;
            2'b01:   w_res = in_a >> in_b;
            2'b11:   w_res = w_a_s >>> in_b;
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_dat[i] <= '0;
                r_tag[i] <= '0;
                r_err[i] <= 1'b0;
            end
        end else if (flush) begin
            // Any same-edge input is dropped; a same-edge output already left downstream.
            r_state <= ST_EMPTY;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_dat[r_tail] <= w_res;
                r_tag[r_tail] <= in_tag;
                r_err[r_tail] <= w_err;
                r_tail        <= ~r_tail;
            end
            if (w_out_fire) begin
                r_head <= ~r_head;
            end
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) r_state <= ST_ONE;
                end
                ST_ONE: begin
                    if (w_in_fire && !w_out_fire)      r_state <= ST_FULL;
                    else if (!w_in_fire && w_out_fire) r_state <= ST_EMPTY;
                end
                ST_FULL: begin
                    if (w_out_fire) r_state <= ST_ONE;
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: doc/shift_stage.md
SHIFT_STAGE -- requirements
Module: shift_stage

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits.
REQ-002 Parameter SHIFT, default $clog2(WIDTH), shift-amount width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  synchronous pipeline flush, discards all held entries.
REQ-006 in_valid  input  1  upstream presents an operation.
REQ-007 in_ready  output  1  stage accepts an operation this cycle.
REQ-008 in_a  input  WIDTH  operand to shift.
REQ-009 in_b  input  SHIFT  shift amount, unsigned, 0..WIDTH-1.
REQ-010 in_op  input  2  operation: 00 SLL, 01 SRL, 11 SRA, 10 reserved.
REQ-011 in_tag  input  5  destination-register tag, carried unchanged.
REQ-012 out_valid  output  1  result available downstream.
REQ-013 out_ready  input  1  downstream accepts the result this cycle.
REQ-014 out_o  output  WIDTH  shift result.
REQ-015 out_tag  output  5  tag of the result on out_o.
REQ-016 out_err  output  1  result came from a reserved op.

Function
REQ-017 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready at a rising edge.
REQ-018 Result computed at input transfer and stored with its tag and err bit in a 2-entry in-order buffer (head, tail pointers, 2-bit count).
REQ-019 SLL: out_o = in_a << in_b, zero fill.
REQ-020 SRL: out_o = in_a >> in_b, zero fill.
REQ-021 SRA: out_o = in_a >> in_b, vacated bits filled with in_a[WIDTH-1].
REQ-022 in_b = 0: out_o = in_a for all valid ops.
REQ-023 Reserved op 10: out_o = in_a unshifted, out_err = 1; all other ops out_err = 0.
REQ-024 Latency: operation accepted at edge N appears on out_* immediately after edge N when buffer was empty (1 cycle), no combinational path from in_* to out_*.
REQ-025 States by count: EMPTY (0), ONE (1), FULL (2); out_valid = (count != 0); in_ready = (count != 2), driven from registered state only, no dependency on out_ready.
REQ-026 EMPTY: in transfer -> ONE.
REQ-027 ONE: in only -> FULL; out only -> EMPTY; in and out same edge -> ONE, new entry becomes head next cycle.
REQ-028 FULL: in_ready = 0; out transfer -> ONE; in_valid ignored.
REQ-029 Results leave in acceptance order; out_o/out_tag/out_err held stable while out_valid && !out_ready.
REQ-030 Pointers wrap modulo 2.
REQ-031 flush at an edge: count, head, tail -> 0; any in transfer on that edge discarded; any out transfer on that edge still counts as consumed downstream.
REQ-032 out_o, out_tag, out_err equal the head entry when out_valid = 1; don't-care when out_valid = 0 but never X after reset (entries reset to 0).

Reset
REQ-033 rst asserted: count, head, tail, all entries cleared to 0 immediately without a clock edge.
REQ-034 During and after reset until the first in transfer: out_valid = 0, in_ready = 1, out_o = 0, out_tag = 0, out_err = 0.
REQ-035 Reset mid-operation discards all buffered results; no result emitted for operations accepted before reset.
REQ-036 First in transfer accepted at the first rising edge after rst deasserts.

Verification
REQ-037 Reset then SLL a=0x0000_0001 b=31 tag=3, out_ready=1 -> next cycle out_valid=1, out_o=0x8000_0000, out_tag=3, out_err=0.
REQ-038 SRA a=0x8000_0000 b=4, then SRL same operands -> out_o=0xF800_0000 then 0x0800_0000, in order.
REQ-039 out_ready=0, three back-to-back ops (tags 1,2,3) -> in_ready falls after tag 2 accepted, tag 3 held upstream; release out_ready -> tags 1,2,3 out in order, no loss, no duplicate.
REQ-040 Reserved op 10 a=0x1234_5678 b=8 -> out_o=0x1234_5678, out_err=1.
REQ-041 FULL buffer, flush with in_valid=1 same edge -> next cycle out_valid=0, in_ready=1, flushed op never emitted.
REQ-042 rst asserted asynchronously between edges with count=2 -> out_valid=0, out_o=0 immediately, before the next clock edge.
